// File: rtl/shift_deserializer.sv
// Serial-in / parallel-out receiver, LSB first, with a single-entry valid/ready output register.
// Define SHIFT_DESER_PARITY_EN to append an even-parity bit to each frame and report dout_perr.
module shift_deserializer #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ena,
    input  logic             sin,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             ovr_clr,
`ifdef SHIFT_DESER_PARITY_EN
    output logic             dout_perr,
`endif
    output logic [CW-1:0]    bit_cnt
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             load;
    logic             drop;

`ifdef SHIFT_DESER_PARITY_EN
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             perr_q, perr_d;

    always_comb begin
        shifted = {sin, sreg_q[WIDTH-1:1]};
        word    = sreg_q;
        sreg_d  = sreg_q;
        // The parity slot is sampled but never shifted into the data word.
        if (ena && (sof || cnt_q != LAST))
            sreg_d = shifted;
    end
`else
    // The oldest bit drops out on the completing shift, so WIDTH-1 bits of history suffice.
    logic [WIDTH-2:0] sreg_q, sreg_d;

    always_comb begin
        shifted = {sin, sreg_q};
        word    = shifted;
        sreg_d  = sreg_q;
        if (ena)
            sreg_d = shifted[WIDTH-1:1];
    end
`endif

    assign complete = ena && !sof && (cnt_q == LAST);
    assign load     = complete && (!vld_q || dout_ready);
    assign drop     = complete && vld_q && !dout_ready;

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;
        if (ena) begin
            if (sof)
                cnt_d = CW'(1);
            else if (cnt_q == LAST)
                cnt_d = '0;
            else
                cnt_d = cnt_q + CW'(1);
        end
        if (load) begin
            dout_d = word;
            vld_d  = 1'b1;
        end else if (vld_q && dout_ready) begin
            vld_d  = 1'b0;
        end
        if (drop)
            ovr_d = 1'b1;
        else if (ovr_clr)
            ovr_d = 1'b0;
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_comb begin
        perr_d = perr_q;
        if (load)
            perr_d = (^sreg_q) ^ sin;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
`ifdef SHIFT_DESER_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
`ifdef SHIFT_DESER_PARITY_EN
    assign dout_perr  = perr_q;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: scoreboard of expected words, checked when each word lands.
module tb_shift_deserializer;
    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             ena = 1'b0;
    logic             sin = 1'b0;
    logic             sof = 1'b0;
    logic             dout_ready = 1'b0;
    logic             ovr_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;
`ifdef SHIFT_DESER_PARITY_EN
    logic             dout_perr;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ena        (ena),
        .sin        (sin),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
`ifdef SHIFT_DESER_PARITY_EN
        .dout_perr  (dout_perr),
`endif
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed %0h expected nothing queued", tag, dout);
        end else begin
            e = exp_q.pop_front();
            chk(tag, dout, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        ena = 1'b1; sin = b; sof = s;
        step();
        ena = 1'b0; sin = 1'b0; sof = 1'b0;
    endtask

    // Disabled cycle with junk on sin/sof, which must be ignored.
    task automatic gap();
        ena = 1'b0; sin = 1'b1; sof = 1'b1;
        step();
        sin = 1'b0; sof = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic s0, input logic rdy_last);
        for (int i = 0; i < WIDTH; i++) begin
`ifndef SHIFT_DESER_PARITY_EN
            if (i == WIDTH - 1) dout_ready = rdy_last;
`endif
            send_bit(w[i], s0 && (i == 0));
        end
`ifdef SHIFT_DESER_PARITY_EN
        dout_ready = rdy_last;
        send_bit(^w, 1'b0);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] b2b[3];
        b2b[0] = 4'h1; b2b[1] = 4'hF; b2b[2] = 4'hA;

        // Reset
        resetn = 1'b0;
        step(); step();
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", bit_cnt, 0);
        resetn = 1'b1;

        // Basic assemble
        dout_ready = 1'b1;
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b1);
        chk("basic_valid", dout_valid, 1);
        pop_chk("basic_dout");
        chk("basic_ovr", overrun, 0);
        step();
        chk("basic_valid_fall", dout_valid, 0);
        chk("basic_dout_keep", dout, 4'hB);

        // Backpressure and overrun
        dout_ready = 1'b0;
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b0, 1'b0);
        chk("bp_valid1", dout_valid, 1);
        pop_chk("bp_dout1");
        chk("bp_ovr1", overrun, 0);
        send_word(4'h6, 1'b0, 1'b0);
        chk("bp_dout_held", dout, 4'hB);
        chk("bp_valid2", dout_valid, 1);
        chk("bp_ovr2", overrun, 1);
        chk("bp_cnt", bit_cnt, 0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("clr_ovr", overrun, 0);
        chk("clr_valid", dout_valid, 1);
        ovr_clr = 1'b1;
        send_word(4'h5, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        chk("setwins_ovr", overrun, 1);
        chk("setwins_dout", dout, 4'hB);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        dout_ready = 1'b1;
        step();
        chk("drain_valid", dout_valid, 0);
        chk("drain_ovr", overrun, 0);

        // Back-to-back stream, no idle cycles between words
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(b2b[k]);
            send_word(b2b[k], 1'b0, 1'b1);
            chk("b2b_valid", dout_valid, 1);
            pop_chk("b2b_dout");
        end
        step();
        chk("b2b_valid_fall", dout_valid, 0);
        chk("b2b_ovr", overrun, 0);

        // Drain and complete in the same cycle
        dout_ready = 1'b0;
        exp_q.push_back(4'h3);
        send_word(4'h3, 1'b0, 1'b0);
        chk("dc_valid1", dout_valid, 1);
        pop_chk("dc_dout1");
        exp_q.push_back(4'hC);
        send_word(4'hC, 1'b0, 1'b1);
        chk("dc_valid2", dout_valid, 1);
        pop_chk("dc_dout2");
        chk("dc_ovr", overrun, 0);
        step();
        chk("dc_valid_fall", dout_valid, 0);

        // Realign with sof and ena gaps
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ra_cnt2", bit_cnt, 2);
        exp_q.push_back(4'h4);
        send_bit(1'b0, 1'b1);
        chk("ra_cnt_sof", bit_cnt, 1);
        gap();
        chk("ra_cnt_gap", bit_cnt, 1);
        send_bit(1'b0, 1'b0);
        gap();
        send_bit(1'b1, 1'b0);
        gap();
        chk("ra_valid_pre", dout_valid, 0);
        send_bit(1'b0, 1'b0);
`ifdef SHIFT_DESER_PARITY_EN
        send_bit(1'b1, 1'b0);
`endif
        chk("ra_valid", dout_valid, 1);
        pop_chk("ra_dout");
        chk("ra_cnt_wrap", bit_cnt, 0);
        chk("ra_ovr", overrun, 0);

        // Reset mid-word while a word is held
        dout_ready = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("mr_cnt3", bit_cnt, 3);
        chk("mr_valid_held", dout_valid, 1);
        resetn = 1'b0;
        ena = 1'b1; sin = 1'b1; sof = 1'b1; dout_ready = 1'b1; ovr_clr = 1'b0;
        step();
        ena = 1'b0; sin = 1'b0; sof = 1'b0; dout_ready = 1'b0;
        resetn = 1'b1;
        chk("mr_cnt0", bit_cnt, 0);
        chk("mr_valid", dout_valid, 0);
        chk("mr_dout", dout, 0);
        exp_q.push_back(4'h9);
        send_word(4'h9, 1'b0, 1'b1);
        chk("mr_clean_valid", dout_valid, 1);
        pop_chk("mr_clean_dout");

`ifdef SHIFT_DESER_PARITY_EN
        begin
            logic [WIDTH-1:0] wb;
            wb = 4'hB;
            exp_q.push_back(wb);
            send_word(wb, 1'b0, 1'b1);
            pop_chk("par_good_dout");
            chk("par_good_perr", dout_perr, 0);
            exp_q.push_back(wb);
            for (int i = 0; i < WIDTH; i++) send_bit(wb[i], 1'b0);
            send_bit(1'b0, 1'b0);
            chk("par_bad_valid", dout_valid, 1);
            pop_chk("par_bad_dout");
            chk("par_bad_perr", dout_perr, 1);
        end
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-in / parallel-out receiver. It is the counterpart of the team's parallel-load, right-shifting serializer, which emits LSB-first.
- Collects WIDTH serial bits, presented LSB first and qualified by ena, into a word.
- Hands the word off over a single-entry valid/ready output register.
- Detects overrun. Supports frame realignment through a start-of-frame strobe.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset, sampled on posedge clk
- ena  in  1  serial bit valid; sin is consumed only when ena=1
- sin  in  1  serial data bit, LSB of word first
- sof  in  1  start of frame; qualified by ena; marks sin as bit 0 of a new word
- dout  out  WIDTH  assembled word; stable while dout_valid=1
- dout_valid  out  1  output register holds an unconsumed word
- dout_ready  in  1  consumer accepts dout when dout_valid and dout_ready are both 1
- overrun  out  1  sticky; a completed word was dropped
- ovr_clr  in  1  clears overrun
- bit_cnt  out  CW  bits collected in the current partial word, 0..WIDTH-1

Behaviour:
- Reset (resetn=0 at posedge): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
  - Reset overrides all other inputs.
  - A partial word in progress is discarded.
- Shift (ena=1): sreg <= {sin, sreg[WIDTH-1:1]}, which is a right shift inserting at the MSB.
  - After WIDTH shifts, sreg[0] holds the first bit received.
- ena=0: sreg and bit_cnt hold. sin and sof are ignored.
- Counter, ena=1 and sof=0: bit_cnt increments. When bit_cnt=WIDTH-1, the word completes and bit_cnt wraps to 0.
- Counter, ena=1 and sof=1: the partial word is abandoned; sin becomes bit 0 and bit_cnt <= 1.
  - sof is not an error and does not set overrun.
  - If also WIDTH=1 then it would complete, but this is illegal by range.
- Completion: the completed word is {sin, sreg[WIDTH-1:1]}.
  - Load condition: dout_valid=0, or (dout_valid=1 and dout_ready=1) in the same cycle.
  - Load condition true: dout <= completed word and dout_valid <= 1.
  - Latency: dout_valid rises on the edge that samples the last bit, i.e. it is visible the cycle after that bit is presented.
- Overrun: completion while dout_valid=1 and dout_ready=0.
  - New word dropped; dout unchanged; overrun <= 1.
  - Shifting and counting continue normally.
- Drain: dout_valid=1, dout_ready=1 and no completion in that cycle -> dout_valid <= 0. dout keeps its last value.
- Simultaneous drain and completion -> back-to-back transfer. dout_valid stays 1 with the new word; no overrun.
- Overrun clear: ovr_clr=1 -> overrun <= 0, unless an overrun occurs in the same cycle, in which case set wins.
- Throughput: one word per WIDTH enabled cycles when dout_ready is held at 1. There are no bubbles.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; bit WIDTH is an even-parity bit over the data bits.
  - bit_cnt range becomes 0..WIDTH and CW is sized to match.
  - Completion occurs on the parity bit. The word is sreg as it stands before that shift; the parity bit is not shifted into the word.
  - Adds output port dout_perr (1 bit), loaded together with dout. It is 1 when XOR(data bits, parity bit) = 1.
  - dout_perr resets to 0.
  - Overrun and sof rules are unchanged. sof on the parity slot restarts the frame.
- Undefined:
  - Frame is WIDTH bits.
  - Port dout_perr does not exist.
  - Behaviour is exactly as described above.

Test Plan:
- Basic assemble (WIDTH=4): resetn low 2 cycles; then ena=1, dout_ready=1, sin=1,1,0,1 with sof=1 on the first bit -> dout=4'hB and dout_valid=1 for exactly 1 cycle after the 4th bit; overrun=0.
- Backpressure/overrun: dout_ready=0; send 4'hB then 4'h6 (bits 0,1,1,0) -> dout stays 4'hB with dout_valid=1; overrun=1 after the 8th bit. Then ovr_clr=1 -> overrun=0. Then dout_ready=1 -> dout_valid falls.
- Back-to-back: dout_ready=1 continuous; stream 4'h1, 4'hF, 4'hA -> three valid words, each held one cycle at an interval of 4 cycles; no overrun.
- Drain-and-complete same cycle: dout holds 4'h3 with ready=0; raise ready on the completing bit of 4'hC -> dout=4'hC, dout_valid stays 1, overrun=0.
- Realign/ena gaps: send 2 bits, then sof=1 with bits 0,0,1,0 interleaved with ena=0 cycles -> dout=4'h4; bit_cnt reads 1 after the sof bit.
- Reset mid-word and parity: resetn=0 after 3 bits -> bit_cnt=0 and dout_valid=0; the next 4 bits yield a clean word. With SHIFT_DESER_PARITY_EN, send 4'hB with parity 1 -> dout_perr=0; send 4'hB with parity 0 -> dout_perr=1.
